// File: rtl/team_06_pkg.sv
// team_06_pkg: shared waveform encoding and LFO shaping for the team_06 tremolo.
package team_06_pkg;
   typedef enum logic [1:0] {WAVE_TRI, WAVE_SQR, WAVE_SAW, WAVE_RSV} wave_sel_t;
   // p holds the top l+1 phase bits right-aligned; the result is an l-bit LFO value
   function automatic logic [31:0] lfo_shape(input logic [31:0] p, input int l, input wave_sel_t w);
      logic [31:0] m;
      logic msb;
      m = (32'd1 << l) - 32'd1;
      msb = |(p & (32'd1 << l));
      return w == WAVE_SQR ? (msb ? 32'd0 : m) :
             w == WAVE_SAW ? ~(p >> 1) & m :
             (msb ? ~p & m : p & m);
   endfunction
endpackage

// File: rtl/team_06_tremolo_lfo.sv
// team_06_tremolo_lfo: phase accumulator plus waveform shaper, advanced once per accepted sample.
module team_06_tremolo_lfo
   import team_06_pkg::*;
#(
   parameter int PHASE_W = 16,
   parameter int RATE_W  = 8,
   parameter int LFO_W   = 8
) (
   input  logic              clkdiv,
   input  logic              rst_n,
   input  logic              step,
   input  logic [RATE_W-1:0] rate,
   input  logic              phase_sync,
   input  logic [1:0]        wave_sel,
   output logic [LFO_W-1:0]  lfo
);
   logic [PHASE_W-1:0] phase;
   logic [PHASE_W-1:0] ph;
   always_ff @(posedge clkdiv or negedge rst_n)
      if (!rst_n) phase <= '0;
      else if (phase_sync) phase <= '0;
      else if (step) phase <= phase + PHASE_W'(rate);
   // a sync arriving with a sample makes that sample see phase 0
   assign ph = phase_sync ? '0 : phase;
   assign lfo = LFO_W'(lfo_shape(32'(ph >> (PHASE_W - LFO_W - 1)), LFO_W, wave_sel_t'(wave_sel)));
endmodule

// File: rtl/team_06_tremolo_mod.sv
// team_06_tremolo_mod: LFO-driven amplitude modulation of an unsigned sample stream.
// Three-stage pipeline: latch sample+LFO, derive gain, scale sample.
module team_06_tremolo_mod
   import team_06_pkg::*;
#(
   parameter int DATA_W  = 8,
   parameter int PHASE_W = 16,
   parameter int RATE_W  = 8,
   parameter int LFO_W   = 8
) (
   input  logic              clkdiv,
   input  logic              rst_n,
   input  logic              en,
   input  logic              sample_valid,
   input  logic [DATA_W-1:0] audio_in,
   input  logic [RATE_W-1:0] rate,
   input  logic [LFO_W-1:0]  depth,
   input  logic [1:0]        wave_sel,
   input  logic              phase_sync,
   output logic [DATA_W-1:0] audio_out,
   output logic              out_valid,
   output logic [LFO_W-1:0]  lfo_out
);
   localparam logic [LFO_W:0] UNITY = {1'b1, {LFO_W{1'b0}}};
   logic [LFO_W-1:0]  lfo, l1, d1, inv_l;
   logic [DATA_W-1:0] a1, a2;
   logic [LFO_W:0]    g2;
   logic              v1, v2, e1;
   team_06_tremolo_lfo #(.PHASE_W(PHASE_W), .RATE_W(RATE_W), .LFO_W(LFO_W)) u_lfo (
      .clkdiv(clkdiv), .rst_n(rst_n), .step(sample_valid & en), .rate(rate),
      .phase_sync(phase_sync), .wave_sel(wave_sel), .lfo(lfo)
   );
   assign inv_l = ~l1;
   always_ff @(posedge clkdiv or negedge rst_n)
      if (!rst_n) begin
         {v1, e1, a1, l1, d1} <= '0;
         {v2, a2, g2} <= '0;
         {out_valid, audio_out, lfo_out} <= '0;
      end else begin
         lfo_out <= lfo;
         v1 <= sample_valid;
         if (sample_valid) {e1, a1, l1, d1} <= {en, audio_in, lfo, depth};
         v2 <= v1;
         // attenuation never exceeds 2^L-1, so gain stays within 1..2^L
         if (v1) begin
            a2 <= a1;
            g2 <= e1 ? UNITY - (LFO_W+1)'(({{LFO_W{1'b0}}, d1} * {{LFO_W{1'b0}}, inv_l}) >> LFO_W) : UNITY;
         end
         out_valid <= v2;
         if (v2) audio_out <= DATA_W'(({{(LFO_W+1){1'b0}}, a2} * {{DATA_W{1'b0}}, g2}) >> LFO_W);
      end
endmodule
